// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw buttons in, debounced level and edge pulses out.
// master = the side that supplies raw buttons and consumes the conditioned outputs.
// slave  = the conditioner itself.
interface btn_conditioner_if;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic       any_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_press
    );
endinterface

// File: rtl/btn_conditioner.sv
// Five-button conditioner: two-flop synchronizer, per-bit debounce counter,
// registered press/release pulses and optional auto-repeat.
// Bit order of every 5-bit vector: {bt_st, bt_d, bt_s, bt_a, bt_w}, 1 = pressed.
// Optional feature macro: BTN_AUTOREPEAT_EN (per-bit repeat FSM + counter).
//
// Repeat FSM (per bit, only with BTN_AUTOREPEAT_EN):
//   state         | meaning
//   RPT_IDLE      | button released, nothing to repeat
//   RPT_HOLD_WAIT | press accepted, waiting REPEAT_DELAY for first repeat
//   RPT_REPEAT    | repeating every REPEAT_PERIOD until the level falls
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic               clk,
    input  logic               rst_n,
    btn_conditioner_if.slave   bus
);
    localparam int NB    = 5;
    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on which the next mismatching sample completes the debounce.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] level_q;
    logic [NB-1:0] level_d;
    logic [NB-1:0] press_q;
    logic [NB-1:0] press_d;
    logic [NB-1:0] release_q;
    logic [NB-1:0] release_d;
    logic [NB-1:0] toggle;
    logic [NB-1:0] rise;
    logic [NB-1:0] fall;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive mismatching samples; toggle when the run completes.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    toggle[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign level_d   = level_q ^ toggle;
    assign rise      = toggle & ~level_q;
    assign fall      = toggle & level_q;
    assign release_d = fall;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX < 1) ? 1 : $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD_WAIT,
        RPT_REPEAT
    } rpt_state_e;

    rpt_state_e     st_q   [NB];
    rpt_state_e     st_d   [NB];
    logic [RPT_W-1:0] rcnt_q [NB];
    logic [RPT_W-1:0] rcnt_d [NB];
    logic [NB-1:0]  rep_pulse;

    // Repeat FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                st_q[i]   <= RPT_IDLE;
                rcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                st_q[i]   <= st_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    // Repeat FSM next state; a falling level wins over a due repeat so press
    // and release never coincide on one bit.
    always_comb begin
        rep_pulse = '0;
        for (int i = 0; i < NB; i++) begin
            st_d[i]   = st_q[i];
            rcnt_d[i] = rcnt_q[i];
            case (st_q[i])
                RPT_IDLE: begin
                    if (rise[i]) begin
                        st_d[i]   = RPT_HOLD_WAIT;
                        rcnt_d[i] = '0;
                    end
                end
                RPT_HOLD_WAIT: begin
                    if (fall[i]) begin
                        st_d[i]   = RPT_IDLE;
                        rcnt_d[i] = '0;
                    end else if (rcnt_q[i] == DELAY_LAST) begin
                        st_d[i]      = RPT_REPEAT;
                        rcnt_d[i]    = '0;
                        rep_pulse[i] = 1'b1;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (fall[i]) begin
                        st_d[i]   = RPT_IDLE;
                        rcnt_d[i] = '0;
                    end else if (rcnt_q[i] == PERIOD_LAST) begin
                        rcnt_d[i]    = '0;
                        rep_pulse[i] = 1'b1;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    st_d[i]   = RPT_IDLE;
                    rcnt_d[i] = '0;
                end
            endcase
        end
    end

    assign press_d = rise | rep_pulse;
`else
    // Repeat timing is irrelevant in this build; only initial presses pulse.
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

    assign press_d = rise;
`endif

    // Debounce counters, accepted level and registered edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.any_press   = |press_q;
endmodule
